// File: rtl/cpu_run_ctrl.sv
// Run controller for the cpu: loads the entry PC, holds the core idle for a settle
// window, then runs until a branch-to-self halt, a cycle-budget timeout or an abort.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// LOAD   | one-cycle pc_ld pulse with the latched entry PC
// SETTLE | clockthing held low for SETTLE cycles
// RUN    | clockthing high; counting cycles and watching for a halt
// DONE   | halt detected; done sticky until the next accepted start
// TOUT   | budget expired; timeout sticky until the next accepted start
module cpu_run_ctrl #(
  parameter int          PC_W         = 32,
  parameter int          PROG_W       = 2,
  parameter logic [31:0] ENTRY_BASE   = 32'h0040_0020,
  parameter logic [31:0] ENTRY_STRIDE = 32'h0000_1000,
  parameter int          SETTLE       = 3,
  parameter int          HALT_CYC     = 4,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PROG_W-1:0] prog_sel,
  input  logic [CNT_W-1:0]  cycle_budget,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic              pc_ld,
  output logic [PC_W-1:0]   pc_data,
  output logic              clockthing,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int STALL_W = $clog2(HALT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_TOUT   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [SET_W-1:0]   settle_cnt;
  logic [STALL_W-1:0] stall_cnt, stall_nxt;
  logic [PC_W-1:0]    prev_pc;
  logic               run_first;
  logic [CNT_W-1:0]   budget_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [PC_W-1:0]    entry_calc;
  logic               halt_hit, bud_hit;
  logic               pc_ld_nxt, clockthing_nxt, busy_nxt;

  assign entry_calc = PC_W'(ENTRY_BASE) + PC_W'(ENTRY_STRIDE) * PC_W'(prog_sel);
  assign cnt_inc    = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + CNT_W'(1);
  // The first RUN cycle has no earlier RUN-cycle PC to compare against.
  assign stall_nxt  = (run_first || (cpu_pc != prev_pc)) ? '0 : stall_cnt + STALL_W'(1);
  assign halt_hit   = (stall_nxt == STALL_W'(HALT_CYC - 1));
  assign bud_hit    = (budget_q != '0) && (cnt_inc == budget_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_ld      <= 1'b0;
      clockthing <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_ld      <= pc_ld_nxt;
      clockthing <= clockthing_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TOUT: if (start && !abort) state_nxt = S_LOAD;
        S_LOAD:                 state_nxt = S_SETTLE;
        S_SETTLE:               if (settle_cnt == '0) state_nxt = S_RUN;
        S_RUN: begin
          if (halt_hit)     state_nxt = S_DONE;
          else if (bud_hit) state_nxt = S_TOUT;
        end
        default:                state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_ld_nxt      = (state_nxt == S_LOAD);
    clockthing_nxt = (state_nxt == S_RUN);
    busy_nxt       = (state_nxt == S_LOAD) || (state_nxt == S_SETTLE) || (state_nxt == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_data     <= '0;
      budget_q    <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      settle_cnt  <= '0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      run_first   <= 1'b0;
    end else begin
      prev_pc   <= cpu_pc;
      run_first <= (state_nxt == S_RUN) && (state != S_RUN);

      if ((state_nxt == S_LOAD) && (state != S_LOAD)) begin
        pc_data     <= entry_calc;
        budget_q    <= cycle_budget;
        done        <= 1'b0;
        timeout     <= 1'b0;
        cycle_count <= '0;
      end

      if ((state_nxt == S_SETTLE) && (state != S_SETTLE))
        settle_cnt <= SET_W'(SETTLE - 1);
      else if ((state == S_SETTLE) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - SET_W'(1);

      // An abort in RUN discards that cycle: count and flags stay as they were.
      if ((state == S_RUN) && !abort) begin
        cycle_count <= cnt_inc;
        stall_cnt   <= stall_nxt;
        if (halt_hit)     done    <= 1'b1;
        else if (bud_hit) timeout <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized start/abort/reset and
// cpu_pc traffic, every cycle compared against a run-timeline reference model.
module tb_cpu_run_ctrl;

  localparam int SETTLE   = 3;
  localparam int HALT_CYC = 4;
  localparam int W_IDLE = 0, W_BUSY = 1, W_END = 2;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  prog_sel;
  logic [15:0] cycle_budget;
  logic [31:0] cpu_pc;

  logic        pc_ld, clockthing, busy, done, timeout;
  logic [31:0] pc_data;
  logic [15:0] cycle_count;

  logic        pc_ld16, clockthing16, busy16, done16, timeout16;
  logic [15:0] pc_data16;
  logic [15:0] cycle_count16;

  always #5 clk = ~clk;

  cpu_run_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_sel(prog_sel),
    .cycle_budget(cycle_budget), .cpu_pc(cpu_pc), .pc_ld(pc_ld), .pc_data(pc_data),
    .clockthing(clockthing), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  cpu_run_ctrl #(.PC_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_sel(prog_sel),
    .cycle_budget(cycle_budget), .cpu_pc(cpu_pc[15:0]), .pc_ld(pc_ld16), .pc_data(pc_data16),
    .clockthing(clockthing16), .busy(busy16), .done(done16), .timeout(timeout16),
    .cycle_count(cycle_count16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: where the run is, how many cycles since start was accepted,
  // and the PCs seen in the RUN cycles of the current run.
  int          m_where = W_IDLE;
  int          m_t = 0;
  int          m_cnt = 0;
  int          m_budget = 0;
  bit          m_done = 0, m_tout = 0;
  logic [31:0] m_pcd = '0;
  logic [31:0] run_pcs[$];

  bit freeze = 1'b1;
  bit rnd_pc = 1'b0;

  function automatic logic [31:0] entry_of(input int p);
    return 32'h0040_0020 + p * 32'h0000_1000;
  endfunction

  function automatic bit pcs_halted();
    if (run_pcs.size() < HALT_CYC) return 1'b0;
    for (int i = 1; i < HALT_CYC; i++)
      if (run_pcs[i] != run_pcs[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_where = W_IDLE; m_done = 0; m_tout = 0; m_cnt = 0; m_pcd = '0;
    end else if (abort) begin
      m_where = W_IDLE;
    end else if (start && m_where != W_BUSY) begin
      m_where = W_BUSY; m_t = 1; m_pcd = entry_of(int'(prog_sel));
      m_budget = int'(cycle_budget); m_done = 0; m_tout = 0; m_cnt = 0;
      run_pcs.delete();
    end else if (m_where == W_BUSY) begin
      if (m_t >= 2 + SETTLE) begin
        run_pcs.push_back(cpu_pc);
        if (run_pcs.size() > HALT_CYC) void'(run_pcs.pop_front());
        if (m_cnt < 65535) m_cnt++;
        if (pcs_halted()) begin
          m_done = 1; m_where = W_END;
        end else if (m_budget != 0 && m_cnt == m_budget) begin
          m_tout = 1; m_where = W_END;
        end
      end
      m_t++;
    end
  endtask

  task automatic cyc();
    bit e_busy, e_ld, e_ck;
    model_step();
    @(posedge clk);
    #1;
    e_busy = (m_where == W_BUSY);
    e_ld   = e_busy && (m_t == 1);
    e_ck   = e_busy && (m_t >= 2 + SETTLE);
    chk("pc_ld", pc_ld, e_ld);
    chk("pc_data", pc_data, m_pcd);
    chk("clockthing", clockthing, e_ck);
    chk("busy", busy, e_busy);
    chk("done", done, m_done);
    chk("timeout", timeout, m_tout);
    chk("cycle_count", cycle_count, m_cnt);
    chk("pc_ld16", pc_ld16, e_ld);
    chk("pc_data16", pc_data16, m_pcd[15:0]);
    chk("clockthing16", clockthing16, e_ck);
    chk("busy16", busy16, e_busy);
    chk("done16", done16, m_done);
    chk("timeout16", timeout16, m_tout);
    chk("cycle_count16", cycle_count16, m_cnt);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    if (rnd_pc) freeze = ($urandom_range(0, 9) < 7);
    if (!freeze) cpu_pc = cpu_pc + 32'd4;
  endtask

  task automatic launch(input int p, input int bud);
    prog_sel = 2'(p); cycle_budget = 16'(bud); start = 1'b1;
    cyc();
  endtask

  task automatic wait_run(input int max);
    int k = 0;
    while (!clockthing && k < max) begin cyc(); k++; end
    chk("wait_run", clockthing, 1);
  endtask

  task automatic wait_end(input int max);
    int k = 0;
    while (busy && k < max) begin cyc(); k++; end
    chk("wait_end", busy, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; abort = 1'b0; prog_sel = '0; cycle_budget = '0;
    cpu_pc = 32'h0040_0020;
    cyc(); reset = 1'b1; cyc();
    chk("rst_busy", busy, 0);
    chk("rst_pc_data", pc_data, 0);

    // launch program 0, then walk the PC and hold it at 0x0040_0048
    freeze = 1'b1;
    launch(0, 0);
    chk("t2_pc_ld", pc_ld, 1);
    chk("t2_pc_data", pc_data, 32'h0040_0020);
    k = 0;
    while (!clockthing && k < 10) begin cyc(); k++; end
    chk("t2_rise", k, SETTLE + 1);
    freeze = 1'b0;
    repeat (10) cyc();
    chk("t4_hold_pc", cpu_pc, 32'h0040_0048);
    freeze = 1'b1;
    wait_end(20);
    chk("t4_done", done, 1);
    chk("t4_count", cycle_count, 14);
    repeat (3) cyc();
    chk("t4_frozen", cycle_count, 14);
    chk("t4_clk_off", clockthing, 0);

    // synchronous reset in the middle of a run
    freeze = 1'b0;
    launch(1, 0);
    wait_run(10);
    repeat (3) cyc();
    reset = 1'b1; cyc();
    chk("t1_busy", busy, 0);
    chk("t1_clk", clockthing, 0);
    chk("t1_pc_data", pc_data, 0);
    chk("t1_count", cycle_count, 0);

    // entry PC calculation including 16-bit truncation
    launch(2, 0);
    chk("t3_prog2", pc_data, 32'h0040_2020);
    abort = 1'b1; cyc();
    launch(3, 0);
    chk("t3_prog3", pc_data, 32'h0040_3020);
    chk("t3_trunc16", pc_data16, 16'h3020);
    abort = 1'b1; cyc();

    // budget expiry with an always-moving PC, then an unlimited budget
    freeze = 1'b0;
    launch(0, 235);
    wait_end(300);
    chk("t5_timeout", timeout, 1);
    chk("t5_count", cycle_count, 235);
    chk("t5_done", done, 0);
    launch(1, 0);
    repeat (5010) cyc();
    chk("t5_unlim_to", timeout, 0);
    chk("t5_unlim_busy", busy, 1);
    abort = 1'b1; cyc();

    // halt and budget expiring together
    freeze = 1'b1;
    launch(0, HALT_CYC);
    wait_end(20);
    chk("t6_tie_done", done, 1);
    chk("t6_tie_to", timeout, 0);
    chk("t6_tie_cnt", cycle_count, HALT_CYC);

    // start during RUN is ignored; restart from DONE clears status
    freeze = 1'b0;
    launch(1, 0);
    wait_run(10);
    launch(3, 5);
    chk("t6_run_start", pc_data, 32'h0040_1020);
    chk("t6_run_busy", clockthing, 1);
    freeze = 1'b1;
    wait_end(20);
    chk("t6_halted", done, 1);
    launch(0, 0);
    chk("t6_re_done", done, 0);
    chk("t6_re_cnt", cycle_count, 0);
    cyc();
    abort = 1'b1; start = 1'b1; cyc();
    chk("t6_abort_start", busy, 0);
    cyc();
    chk("t6_abort_ld", pc_ld, 0);

    // randomized traffic
    rnd_pc = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        start = 1'b1;
        prog_sel = 2'($urandom_range(0, 3));
        cycle_budget = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      end
      if ($urandom_range(0, 49) == 0) abort = 1'b1;
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
